a2d_spi_resp: RTL and testbench
===============================

A2D_SPI_RESP -- requirements
Module: a2d_spi_resp

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port SS_n, input, 1, SPI select from initiator; asynchronous to clk.
REQ-004 SHALL have port SCLK, input, 1, SPI clock, idles high; asynchronous to clk.
REQ-005 SHALL have port MOSI, input, 1, command bits from initiator.
REQ-006 SHALL have port MISO, output, 1, result bits to initiator.
REQ-007 SHALL have port wr_en, input, 1, load one channel value.
REQ-008 SHALL have port wr_chnl, input, 3, channel to load.
REQ-009 SHALL have port wr_data, input, 12, value to load.
REQ-010 SHALL have port cmd_chnl, output, 3, channel latched from last valid frame.
REQ-011 SHALL have port frm_done, output, 1, one-clk pulse per valid frame.

Function
REQ-012 SHALL double-flop SS_n, SCLK and MOSI, and detect edges on the synchronized copies; pin-to-edge latency is 3 clk.
REQ-013 SHALL require a SCLK half-period of at least 4 clk; faster SCLK is unsupported.
REQ-014 SHALL hold an 8x12 value table; wr_en writes wr_data to entry wr_chnl on the next clk.
REQ-015 SHALL implement states IDLE, SHIFT, COMMIT.
REQ-016 IDLE: on synced SS_n fall, load tx_shft = {4'b0000, table[cmd_chnl]}, clear bit_cnt, go to SHIFT.
REQ-017 SHIFT: on synced SCLK rise, shift MOSI into rx_shft LSB-first-in and increment bit_cnt, saturating at 17.
REQ-018 SHIFT: on synced SCLK fall, shift tx_shft left by one; skip the first fall of the frame.
REQ-019 SHIFT: on synced SS_n rise, go to COMMIT if bit_cnt==16, else go to IDLE and discard the frame.
REQ-020 COMMIT (1 clk): cmd_chnl <= rx_shft[13:11], frm_done=1, then go to IDLE; rx_shft bits other than [13:11] are ignored.
REQ-021 The result returned in a frame SHALL be the table entry of the channel latched by the previous valid frame (pipelined read).
REQ-022 MISO = tx_shft[15] while synced SS_n low; MISO = 0 otherwise.
REQ-023 tx_shft SHALL be a snapshot; a wr_en to the selected channel mid-frame SHALL NOT alter bits being shifted.
REQ-024 SCLK edges while SS_n high SHALL be ignored.

Reset
REQ-025 rst_n low SHALL asynchronously set state=IDLE, MISO=0, cmd_chnl=0, frm_done=0, bit_cnt=0, shift registers=0, table entries=12'h000, synchronizer flops to SS_n=1, SCLK=1, MOSI=0.
REQ-026 Reset mid-frame SHALL abort the frame with no cmd_chnl update; the next frame starts only on a fresh SS_n fall.

Configuration
REQ-027 With A2D_RESP_RAMP_EN defined, each COMMIT SHALL increment the table entry just read by 1, wrapping 12'hFFF to 12'h000; a same-cycle wr_en to that entry SHALL win.
REQ-028 Without A2D_RESP_RAMP_EN, table entries SHALL change only via wr_en or reset.

Structure
REQ-029 Package a2d_pkg SHALL hold the state enum, FRAME_LEN=16, CHNL_W=3, RES_W=12 and the command bit positions [13:11].
REQ-030 The three-signal synchronizer plus edge detect SHALL be sub-module spi_sync_edge.

Verification
REQ-031 Reset, table[0]=12'hABC, two 16-bit frames with cmd chnl 0 -> second frame MISO = 16'h0ABC, cmd_chnl=0.
REQ-032 Frame with cmd 16'h2800 (chnl 5), then frame with table[5]=12'h123 -> MISO 16'h0123, frm_done pulses once per frame.
REQ-033 Frame aborted after 9 SCLK rises -> no frm_done, cmd_chnl unchanged.
REQ-034 17-rise frame -> discarded; a following 16-rise frame is accepted.
REQ-035 wr_en to the selected channel mid-frame changes 12'h111 to 12'h222 -> current frame returns 12'h111, next frame returns 12'h222.
REQ-036 With A2D_RESP_RAMP_EN, table[3]=12'hFFF, three frames on chnl 3 -> returns FFF, 000, 001.

Source files
------------

// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types and frame constants for the a2d_spi_resp SPI responder
package a2d_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
   localparam int FRAME_LEN = 16;
   localparam int CHNL_W    = 3;
   localparam int RES_W     = 12;
   localparam int NUM_CHNL  = 1 << CHNL_W;
   localparam int CMD_HI    = 13;
   localparam int CMD_LO    = 11;
   localparam int CNT_W     = 5;
   localparam logic [CNT_W-1:0] CNT_MAX = 5'd17;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: double-flop SS_n/SCLK/MOSI into clk and flag edges on the synced copies
module spi_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic ss_n_i,
   input  logic sclk_i,
   input  logic mosi_i,
   output logic ss_n_o,
   output logic mosi_o,
   output logic ss_fall_o,
   output logic ss_rise_o,
   output logic sclk_rise_o,
   output logic sclk_fall_o
);
   logic [2:0] ss_q, sclk_q;
   logic [1:0] mosi_q, rdy_q;
   logic       arm_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ss_q   <= '1;
         sclk_q <= '1;
         mosi_q <= '0;
         rdy_q  <= '0;
         arm_q  <= 1'b0;
      end else begin
         ss_q   <= {ss_q[1:0], ss_n_i};
         sclk_q <= {sclk_q[1:0], sclk_i};
         mosi_q <= {mosi_q[0], mosi_i};
         rdy_q  <= {rdy_q[0], 1'b1};
         arm_q  <= arm_q | (rdy_q[1] & ss_q[1]);
      end
   // a fall only counts once SS_n has been seen high after reset
   assign ss_fall_o   = arm_q & ss_q[2] & ~ss_q[1];
   assign ss_rise_o   = ~ss_q[2] & ss_q[1];
   assign sclk_rise_o = ~sclk_q[2] & sclk_q[1];
   assign sclk_fall_o = sclk_q[2] & ~sclk_q[1];
   assign ss_n_o      = ss_q[1];
   assign mosi_o      = mosi_q[1];
endmodule

// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI responder returning pipelined 12-bit channel values; A2D_RESP_RAMP_EN adds post-read increment
module a2d_spi_resp
   import a2d_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              SCLK,
   input  logic              MOSI,
   output logic              MISO,
   input  logic              wr_en,
   input  logic [CHNL_W-1:0] wr_chnl,
   input  logic [RES_W-1:0]  wr_data,
   output logic [CHNL_W-1:0] cmd_chnl,
   output logic              frm_done
);
   state_t               state_q, state_d;
   logic [FRAME_LEN-1:0] tx_q, tx_d, rx_q, rx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CHNL_W-1:0]    chnl_q, chnl_d;
   logic [RES_W-1:0]     tbl_q [NUM_CHNL];
   logic [RES_W-1:0]     tbl_d [NUM_CHNL];
   logic                 ss_s, mosi_s, ss_fall, ss_rise, sclk_rise, sclk_fall;

   spi_sync_edge u_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .ss_n_i      (SS_n),
      .sclk_i      (SCLK),
      .mosi_i      (MOSI),
      .ss_n_o      (ss_s),
      .mosi_o      (mosi_s),
      .ss_fall_o   (ss_fall),
      .ss_rise_o   (ss_rise),
      .sclk_rise_o (sclk_rise),
      .sclk_fall_o (sclk_fall)
   );

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      cnt_d   = cnt_q;
      chnl_d  = chnl_q;
      tbl_d   = tbl_q;
      case (state_q)
         IDLE:
            if (ss_fall) begin
               tx_d    = FRAME_LEN'(tbl_q[chnl_q]);
               cnt_d   = '0;
               state_d = SHIFT;
            end
         SHIFT:
            if (ss_rise) state_d = (cnt_q == CNT_W'(FRAME_LEN)) ? COMMIT : IDLE;
            else begin
               if (sclk_rise) begin
                  rx_d  = {rx_q[FRAME_LEN-2:0], mosi_s};
                  cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 5'd1;
               end
               // the first fall precedes any rise and must not consume bit 15
               if (sclk_fall && cnt_q != '0) tx_d = {tx_q[FRAME_LEN-2:0], 1'b0};
            end
         COMMIT: begin
            chnl_d  = rx_q[CMD_HI:CMD_LO];
            state_d = IDLE;
`ifdef A2D_RESP_RAMP_EN
            tbl_d[chnl_q] = tbl_q[chnl_q] + RES_W'(1);
`endif
         end
         default: state_d = IDLE;
      endcase
      if (wr_en) tbl_d[wr_chnl] = wr_data;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         cnt_q   <= '0;
         chnl_q  <= '0;
         tbl_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         cnt_q   <= cnt_d;
         chnl_q  <= chnl_d;
         tbl_q   <= tbl_d;
      end

   assign MISO     = ~ss_s & tx_q[FRAME_LEN-1];
   assign cmd_chnl = chnl_q;
   assign frm_done = state_q == COMMIT;
endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb_a2d_spi_resp: directed and randomized SPI frames checked against a channel-table model
`timescale 1ns/1ps
module tb_a2d_spi_resp;
`ifdef A2D_RESP_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif
   localparam int H = 6;
   logic        clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, SCLK = 1'b1, MOSI = 1'b0, wr_en = 1'b0;
   logic [2:0]  wr_chnl = '0;
   logic [11:0] wr_data = '0;
   logic        MISO, frm_done;
   logic [2:0]  cmd_chnl;
   int          total = 0, bad = 0, cyc = 0, ss_hi = 0, dcount = 0, nframes = 0;
   int          done_at = -1, chnl_at = 0, d0;
   logic [2:0]  chnl_old = '0, chnl_new = '0, chnl_m = '0, ec;
   logic [11:0] tbl [8];
   logic [15:0] last_word = '0;
   bit          chk_en = 1'b0;

   a2d_spi_resp dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .SCLK     (SCLK),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .wr_en    (wr_en),
      .wr_chnl  (wr_chnl),
      .wr_data  (wr_data),
      .cmd_chnl (cmd_chnl),
      .frm_done (frm_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      ss_hi <= SS_n ? ss_hi + 1 : 0;
   end

   // frame results land 3 clk after SS_n rises (synchronizer + edge), cmd_chnl one clk later
   always @(negedge clk)
      if (chk_en) begin
         ec = (cyc >= chnl_at) ? chnl_new : chnl_old;
         if (frm_done) dcount++;
         total += 2;
         if (frm_done !== (cyc == done_at)) begin
            bad++;
            $display("FAIL frm_done cyc=%0d got=%b exp=%b", cyc, frm_done, cyc == done_at);
         end
         if (cmd_chnl !== ec) begin
            bad++;
            $display("FAIL cmd_chnl cyc=%0d got=%0d exp=%0d", cyc, cmd_chnl, ec);
         end
         if (ss_hi >= 4) begin
            total++;
            if (MISO !== 1'b0) begin
               bad++;
               $display("FAIL miso_idle cyc=%0d got=%b exp=0", cyc, MISO);
            end
         end
      end

   task automatic tk(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic wr(input logic [2:0] ch, input logic [11:0] v);
      wr_en = 1'b1;
      wr_chnl = ch;
      wr_data = v;
      tk(1);
      wr_en = 1'b0;
      tbl[ch] = v;
   endtask

   task automatic frame(input logic [15:0] cmd, input int nbits, input bit live, input bit mid,
                        input logic [11:0] wv);
      logic [15:0] ew, got;
      int          errs;
      logic        eb;
      ew = live ? {4'h0, tbl[chnl_m]} : 16'h0;
      got = '0;
      errs = 0;
      SS_n = 1'b0;
      tk(H);
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = (i < 16) ? cmd[15-i] : 1'b0;
         if (mid && i == 8) wr(chnl_m, wv);
         tk(H);
         eb = (i < 16) ? ew[15-i] : 1'b0;
         if (MISO !== eb) errs++;
         if (i < 16) got[15-i] = MISO;
         SCLK = 1'b1;
         tk(H);
      end
      SS_n = 1'b1;
      if (live && nbits == 16) begin
         done_at  = cyc + 3;
         chnl_old = chnl_m;
         chnl_new = cmd[13:11];
         chnl_at  = cyc + 4;
         if (RAMP) tbl[chnl_m] = tbl[chnl_m] + 12'd1;
         chnl_m = cmd[13:11];
         nframes++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL miso_frame got=%h exp=%h bits_wrong=%0d", got, ew, errs);
      end
      last_word = got;
      tk(12);
   endtask

   initial begin
      foreach (tbl[i]) tbl[i] = '0;
      tk(4);
      check("rst_miso", MISO, 0);
      check("rst_cmd_chnl", cmd_chnl, 0);
      check("rst_frm_done", frm_done, 0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      tk(6);

      wr(3'd0, 12'hABC);
      frame(16'h0000, 16, 1, 0, 0);
      check("first_word", last_word, 16'h0ABC);
      frame(16'h0000, 16, 1, 0, 0);
      check("pipelined_word", last_word, RAMP ? 16'h0ABD : 16'h0ABC);
      check("chnl0", cmd_chnl, 0);

      d0 = dcount;
      frame(16'h2800, 16, 1, 0, 0);
      check("chnl5", cmd_chnl, 5);
      wr(3'd5, 12'h123);
      frame(16'h2800, 16, 1, 0, 0);
      check("word_123", last_word, 16'h0123);
      check("done_per_frame", dcount, d0 + 2);

      d0 = dcount;
      frame(16'h0000, 9, 1, 0, 0);
      check("abort9_done", dcount, d0);
      check("abort9_chnl", cmd_chnl, 5);

      frame(16'h1800, 17, 1, 0, 0);
      check("rise17_done", dcount, d0);
      check("rise17_chnl", cmd_chnl, 5);
      frame(16'h1800, 16, 1, 0, 0);
      check("after17_done", dcount, d0 + 1);
      check("after17_chnl", cmd_chnl, 3);

      wr(3'd3, 12'h111);
      frame(16'h1800, 16, 1, 1, 12'h222);
      check("snapshot_old", last_word, 16'h0111);
      frame(16'h1800, 16, 1, 0, 0);
      check("snapshot_new", last_word, RAMP ? 16'h0223 : 16'h0222);

      wr(3'd3, 12'hFFF);
      frame(16'h1800, 16, 1, 0, 0);
      check("ramp0", last_word, 16'h0FFF);
      frame(16'h1800, 16, 1, 0, 0);
      check("ramp1", last_word, RAMP ? 16'h0000 : 16'h0FFF);
      frame(16'h1800, 16, 1, 0, 0);
      check("ramp2", last_word, RAMP ? 16'h0001 : 16'h0FFF);

      // reset in the middle of a frame while SS_n stays low
      SS_n = 1'b0;
      tk(H);
      SCLK = 1'b0;
      tk(H);
      SCLK = 1'b1;
      tk(H);
      rst_n = 1'b0;
      foreach (tbl[i]) tbl[i] = '0;
      chnl_m = '0;
      chnl_old = '0;
      chnl_new = '0;
      done_at = -1;
      tk(2);
      check("midrst_cmd_chnl", cmd_chnl, 0);
      rst_n = 1'b1;
      tk(2);
      d0 = dcount;
      frame(16'h2800, 16, 0, 0, 0);
      check("midrst_no_done", dcount, d0);
      check("midrst_chnl", cmd_chnl, 0);
      frame(16'h2800, 16, 1, 0, 0);
      check("postrst_word", last_word, 16'h0000);
      check("postrst_chnl", cmd_chnl, 5);

      for (int k = 0; k < 24; k++) begin
         logic [15:0] c;
         int          nb, r;
         c = 16'($urandom);
         r = $urandom_range(0, 9);
         nb = (r == 0) ? 9 : (r == 1) ? 17 : (r == 2) ? 15 : 16;
         if ($urandom_range(0, 1) == 1) wr(3'($urandom), 12'($urandom));
         frame(c, nb, 1, $urandom_range(0, 3) == 0, 12'($urandom));
      end
      check("frame_count", dcount, nframes);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
